// File: rtl/node_evaluator.sv
// rtl/node_evaluator.sv - two-deep sample buffer feeding a linear node accumulator for tree inference
module node_evaluator #(
    parameter int FEATURES         = 3,
    parameter int COEFF_BIT_DEPTH  = 4,
    parameter int BIAS_BIT_DEPTH   = 10,
    parameter int SAMPLE_BIT_DEPTH = 8,
    parameter int ID_WIDTH         = 8,
    localparam int LW    = $clog2(FEATURES),
    localparam int ACC_W = SAMPLE_BIT_DEPTH + COEFF_BIT_DEPTH + $clog2(FEATURES + 1) + 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [FEATURES*SAMPLE_BIT_DEPTH-1:0] in_sample,
    input  logic                                 load_bias,
    input  logic                                 add,
    input  logic                                 mult,
    input  logic                                 is_one,
    input  logic [COEFF_BIT_DEPTH-1:0]           coeff,
    input  logic [BIAS_BIT_DEPTH-1:0]            bias,
    input  logic                                 tree_done,
    input  logic [LW-1:0]                        tree_level,
    input  logic [LW-1:0]                        tree_path,
    output logic                                 child_direction,
    output logic                                 next,
    output logic                                 class_valid,
    output logic [LW-1:0]                        class_level,
    output logic [LW-1:0]                        class_path,
    output logic [ID_WIDTH-1:0]                  class_id,
    output logic                                 err_idle_cmd
);

    localparam int SW   = SAMPLE_BIT_DEPTH;
    localparam int FP_W = (LW > 0) ? LW : 1;
    localparam logic [FP_W-1:0] FP_LAST = FP_W'(FEATURES - 1);
    localparam logic [FP_W-1:0] FP_ONE  = FP_W'((FEATURES > 1) ? 1 : 0);

    logic                         act_v_q, act_v_d, stg_v_q, stg_v_d;
    logic [FEATURES*SW-1:0]       act_sample_q, act_sample_d, stg_sample_q, stg_sample_d;
    logic [ID_WIDTH-1:0]          act_tag_q, act_tag_d, stg_tag_q, stg_tag_d;
    logic [ID_WIDTH-1:0]          tag_cnt_q, tag_cnt_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [FP_W-1:0]              fp_q, fp_d;
    logic                         child_dir_q, child_dir_d;
    logic                         class_valid_q, class_valid_d;
    logic [LW-1:0]                class_level_q, class_level_d, class_path_q, class_path_d;
    logic [ID_WIDTH-1:0]          class_id_q, class_id_d;
    logic                         err_q, err_d;

    logic                         promote, xfer, cmd, cmd_ok, node_last;
    logic [FP_W-1:0]              sel;
    logic signed [SW-1:0]         feat_arr [FEATURES];
    logic signed [SW-1:0]         feat;
    logic signed [ACC_W-1:0]      x_ext, c_ext, b_ext, term, base, sum;

    assign promote  = (tree_done & act_v_q) | ~act_v_q;
    assign in_ready = ~stg_v_q | promote;
    assign xfer     = in_valid & in_ready & ~reset;
    // next is combinational so a bypassed sample is announced in its transfer cycle
    assign next     = promote & (stg_v_q | xfer) & ~reset;

    assign child_direction = child_dir_q;
    assign class_valid     = class_valid_q;
    assign class_level     = class_level_q;
    assign class_path      = class_path_q;
    assign class_id        = class_id_q;
    assign err_idle_cmd    = err_q;

    // Sample buffer: staging/active movement, bypass, tagging and result capture
    always_comb begin
        act_v_d       = act_v_q;
        stg_v_d       = stg_v_q;
        act_sample_d  = act_sample_q;
        stg_sample_d  = stg_sample_q;
        act_tag_d     = act_tag_q;
        stg_tag_d     = stg_tag_q;
        tag_cnt_d     = tag_cnt_q;
        class_valid_d = tree_done & act_v_q;
        class_level_d = class_level_q;
        class_path_d  = class_path_q;
        class_id_d    = class_id_q;
        if (xfer) tag_cnt_d = tag_cnt_q + ID_WIDTH'(1);
        if (tree_done & act_v_q) begin
            class_level_d = tree_level;
            class_path_d  = tree_path;
            class_id_d    = act_tag_q;
        end
        if (promote) begin
            if (stg_v_q) begin
                act_sample_d = stg_sample_q;
                act_tag_d    = stg_tag_q;
                act_v_d      = 1'b1;
                stg_v_d      = xfer;
                if (xfer) begin
                    stg_sample_d = in_sample;
                    stg_tag_d    = tag_cnt_q;
                end
            end else if (xfer) begin
                act_sample_d = in_sample;
                act_tag_d    = tag_cnt_q;
                act_v_d      = 1'b1;
            end else begin
                act_v_d = 1'b0;
            end
        end else if (xfer) begin
            stg_sample_d = in_sample;
            stg_tag_d    = tag_cnt_q;
            stg_v_d      = 1'b1;
        end
    end

    // Unpack the active sample, feature 0 from the MSBs
    always_comb begin
        for (int i = 0; i < FEATURES; i++) begin
            feat_arr[i] = act_sample_q[(FEATURES-i)*SW-1 -: SW];
        end
    end

    // Node datapath: term selection, accumulate, pointer advance and sign capture
    always_comb begin
        cmd       = load_bias | add | mult | is_one;
        cmd_ok    = cmd & act_v_q;
        err_d     = err_q | (cmd & ~act_v_q);
        sel       = load_bias ? '0 : fp_q;
        feat      = feat_arr[sel];
        x_ext     = {{(ACC_W-SW){feat[SW-1]}}, feat};
        c_ext     = {{(ACC_W-COEFF_BIT_DEPTH){coeff[COEFF_BIT_DEPTH-1]}}, coeff};
        b_ext     = {{(ACC_W-BIAS_BIT_DEPTH){bias[BIAS_BIT_DEPTH-1]}}, bias};
        term      = '0;
        if (add) term = is_one ? x_ext : (mult ? x_ext * c_ext : '0);
        base      = load_bias ? b_ext : acc_q;
        sum       = base + term;
        node_last = load_bias ? (FEATURES == 1) : (fp_q == FP_LAST);
        acc_d       = acc_q;
        fp_d        = fp_q;
        child_dir_d = child_dir_q;
        if (cmd_ok & add) begin
            acc_d = sum;
            if (load_bias) fp_d = FP_ONE;
            else if (fp_q != FP_LAST) fp_d = fp_q + FP_W'(1);
            if (node_last) child_dir_d = sum[ACC_W-1];
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            act_v_q       <= 1'b0;
            stg_v_q       <= 1'b0;
            act_sample_q  <= '0;
            stg_sample_q  <= '0;
            act_tag_q     <= '0;
            stg_tag_q     <= '0;
            tag_cnt_q     <= '0;
            acc_q         <= '0;
            fp_q          <= '0;
            child_dir_q   <= 1'b0;
            class_valid_q <= 1'b0;
            class_level_q <= '0;
            class_path_q  <= '0;
            class_id_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            act_v_q       <= act_v_d;
            stg_v_q       <= stg_v_d;
            act_sample_q  <= act_sample_d;
            stg_sample_q  <= stg_sample_d;
            act_tag_q     <= act_tag_d;
            stg_tag_q     <= stg_tag_d;
            tag_cnt_q     <= tag_cnt_d;
            acc_q         <= acc_d;
            fp_q          <= fp_d;
            child_dir_q   <= child_dir_d;
            class_valid_q <= class_valid_d;
            class_level_q <= class_level_d;
            class_path_q  <= class_path_d;
            class_id_q    <= class_id_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_node_evaluator.sv
// tb/tb_node_evaluator.sv - self-checking bench for node_evaluator
module tb_node_evaluator;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              iv, in_ready;
    logic signed [7:0] f0, f1, f2;
    logic [23:0]       in_sample;
    logic              lb, ad, mu, one;
    logic signed [3:0] coeff;
    logic signed [9:0] bias;
    logic              td;
    logic [1:0]        lvl, path;
    logic              child_direction, next, class_valid, err_idle_cmd;
    logic [1:0]        class_level, class_path;
    logic [7:0]        class_id;

    assign in_sample = {f0, f1, f2};

    node_evaluator dut (
        .clk(clk), .reset(reset),
        .in_valid(iv), .in_ready(in_ready), .in_sample(in_sample),
        .load_bias(lb), .add(ad), .mult(mu), .is_one(one),
        .coeff(coeff), .bias(bias),
        .tree_done(td), .tree_level(lvl), .tree_path(path),
        .child_direction(child_direction), .next(next),
        .class_valid(class_valid), .class_level(class_level),
        .class_path(class_path), .class_id(class_id),
        .err_idle_cmd(err_idle_cmd)
    );

    always #5 clk = ~clk;

    typedef struct { int x0; int x1; int x2; int tag; } ent_t;
    typedef struct { int x0; int x1; int x2; int b; int c1; int c2; int dir; } vec_t;

    ent_t q[$];
    int   m_acc, m_fp, m_tag, m_cid, m_lvl, m_path;
    bit   m_dir, m_cv, m_err;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_next = 0;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        iv = 0; f0 = 0; f1 = 0; f2 = 0;
        lb = 0; ad = 0; mu = 0; one = 0; coeff = 0; bias = 0;
        td = 0; lvl = 0; path = 0;
    endtask

    task automatic model_clear();
        q.delete();
        m_acc = 0; m_fp = 0; m_tag = 0; m_dir = 0; m_cv = 0; m_err = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_next", next, 0);
        chk("rst_child_direction", child_direction, 0);
        chk("rst_class_valid", class_valid, 0);
        chk("rst_class_level", class_level, 0);
        chk("rst_class_path", class_path, 0);
        chk("rst_class_id", class_id, 0);
        chk("rst_err_idle_cmd", err_idle_cmd, 0);
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_clear();
        check_reset_values();
    endtask

    // One clock with the currently driven inputs; queue model front = active sample
    task automatic cycle();
        int   size0, xi, t;
        bit   xfer, pop, exp_next;
        ent_t e;
        #1;
        size0    = q.size();
        xfer     = iv && (size0 < 2 || td);
        pop      = td && size0 > 0;
        exp_next = (size0 == 0 || td) && (size0 - int'(pop) + int'(xfer)) > 0;
        chk("in_ready", in_ready, int'(size0 < 2 || td));
        chk("next", next, exp_next);
        if (next) n_next++;
        if ((lb || ad || mu || one) && size0 == 0) m_err = 1;
        if (size0 > 0 && ad) begin
            e  = q[0];
            xi = (lb || m_fp == 0) ? e.x0 : (m_fp == 1 ? e.x1 : e.x2);
            t  = one ? xi : (mu ? xi * int'(coeff) : 0);
            if (lb) begin
                m_acc = int'(bias) + t;
                m_fp  = 1;
            end else begin
                m_acc = m_acc + t;
                if (m_fp == 2) m_dir = (m_acc < 0);
                else m_fp++;
            end
        end
        m_cv = pop;
        if (pop) begin
            m_cid = q[0].tag; m_lvl = lvl; m_path = path;
            void'(q.pop_front());
        end
        if (xfer) begin
            e.x0 = f0; e.x1 = f1; e.x2 = f2; e.tag = m_tag;
            q.push_back(e);
            m_tag = (m_tag + 1) % 256;
        end
        @(posedge clk); #1;
        chk("child_direction", child_direction, m_dir);
        chk("class_valid", class_valid, m_cv);
        chk("err_idle_cmd", err_idle_cmd, m_err);
        if (m_cv) begin
            chk("class_id", class_id, m_cid);
            chk("class_level", class_level, m_lvl);
            chk("class_path", class_path, m_path);
        end
    endtask

    initial begin
        tbl[0] = '{10, -3, 5, -20, 2, -1, 1};
        tbl[1] = '{10, -3, 5, 30, 2, -5, 0};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0, -1, 0, 0, 1};
        tbl[4] = '{127, 127, 127, 511, 7, 7, 0};
        tbl[5] = '{-128, -128, -128, -512, 7, 7, 1};
        tbl[6] = '{-128, -128, -128, 511, -8, -8, 0};
        tbl[7] = '{1, 0, 0, -1, 0, 0, 0};
        tbl[8] = '{20, 0, -3, 0, 0, 7, 1};

        drive_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;

        // table of single-node evaluations, one fresh sample each
        for (int i = 0; i < 9; i++) begin
            do_reset();
            iv = 1; f0 = 8'(tbl[i].x0); f1 = 8'(tbl[i].x1); f2 = 8'(tbl[i].x2);
            cycle();
            iv = 0;
            lb = 1; ad = 1; one = 1; bias = 10'(tbl[i].b);
            cycle();
            lb = 0; one = 0; mu = 1; coeff = 4'(tbl[i].c1);
            cycle();
            coeff = 4'(tbl[i].c2);
            cycle();
            chk($sformatf("tbl%0d_dir", i), child_direction, tbl[i].dir);
            mu = 0; coeff = 0;
            cycle();
            chk($sformatf("tbl%0d_hold", i), child_direction, tbl[i].dir);
            ad = 0;
        end

        // idle source: two accepted, then back-pressure, single next
        do_reset();
        n_next = 0;
        iv = 1;
        for (int i = 0; i < 4; i++) begin
            f0 = 8'(i + 1); f1 = 8'(i + 2); f2 = 8'(i + 3);
            cycle();
        end
        #1;
        chk("idle_ready_low", in_ready, 0);
        chk("idle_next_once", n_next, 1);

        // tree_done with tag 0 active, tag 1 staged, new sample tag 2 arriving
        td = 1; lvl = 2; path = 2'b01; f0 = 8'd99;
        #1;
        chk("done_in_ready", in_ready, 1);
        chk("done_next", next, 1);
        cycle();
        chk("done_class_valid", class_valid, 1);
        chk("done_class_id", class_id, 0);
        chk("done_class_level", class_level, 2);
        chk("done_class_path", class_path, 1);
        iv = 0; lvl = 1; path = 2'b10;
        cycle();
        chk("done2_class_id", class_id, 1);
        cycle();
        chk("done3_class_id", class_id, 2);
        cycle();
        chk("done_empty_no_class", class_valid, 0);
        td = 0;

        // commands with no sample loaded are ignored and flagged
        do_reset();
        lb = 1; ad = 1; one = 1; bias = -10'sd100;
        cycle();
        lb = 0; one = 0; bias = 0;
        cycle();
        cycle();
        chk("idle_cmd_err", err_idle_cmd, 1);
        chk("idle_cmd_dir", child_direction, 0);
        ad = 0;

        // reset in the middle of a node discards samples and partial sum
        do_reset();
        iv = 1; f0 = 8'sd10; f1 = -8'sd3; f2 = 8'sd5;
        cycle();
        f0 = 8'sd7;
        lb = 1; ad = 1; one = 1; bias = -10'sd20;
        cycle();
        iv = 0; lb = 0; one = 0; mu = 1; coeff = 4'sd2;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        drive_idle();
        model_clear();
        check_reset_values();
        td = 1;
        cycle();
        chk("mid_reset_no_class", class_valid, 0);

        // randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            iv    = $urandom_range(0, 1);
            f0    = 8'($urandom); f1 = 8'($urandom); f2 = 8'($urandom);
            lb    = ($urandom_range(0, 4) == 0);
            ad    = ($urandom_range(0, 3) != 0);
            mu    = $urandom_range(0, 1);
            one   = ($urandom_range(0, 3) == 0);
            coeff = 4'($urandom);
            bias  = 10'($urandom);
            td    = ($urandom_range(0, 6) == 0);
            lvl   = 2'($urandom);
            path  = 2'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
